// File: rtl/humidity_sensor_filter.sv
// humidity_sensor_filter: syncs and debounces two dry sensors, raises a latched persistence alarm, and counts dry events.
// Optional: define HUMIDITY_ALARM_BLINK_EN so alarm blinks every clk_2 edge while in ALARM.
module humidity_sensor_filter #(
  parameter int DB_CYCLES    = 3,
  parameter int ALARM_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [1:0]       sensor_raw,
  input  logic             ack,
  output logic [1:0]       dry,
  output logic             alarm,
  output logic             arming,
  output logic [CNT_W-1:0] dry_events
);
  localparam int SW = CNT_W + 1;
  typedef enum logic [1:0] {IDLE, ARMING, ALARM} state_t;
  state_t           st_q, st_d;
  logic [1:0]       s1_q, s2_q, dry_q, dry_d, rise;
  logic [3:0]       cnt_q [2];
  logic [3:0]       cnt_d [2];
  logic [CNT_W-1:0] ev_q, ev_d;
  logic [SW-1:0]    sum;
  logic [7:0]       tmr_q, tmr_d;
  logic             alarm_q, alarm_d, arming_q, arming_d, both;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dry_d[i] = dry_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != dry_q[i]) begin
        if (cnt_q[i] == 4'(DB_CYCLES - 1)) dry_d[i] = ~dry_q[i];
        else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end
  // The carry bit of the widened sum means we passed the maximum; +2 at max-1 lands there too.
  assign rise = dry_d & ~dry_q;
  assign sum  = {1'b0, ev_q} + SW'(rise[0]) + SW'(rise[1]);
  assign ev_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign both = dry_q == 2'b11;
  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    case (st_q)
      IDLE: if (both) begin
        if (ALARM_CYCLES == 1) st_d = ALARM;
        else begin
          st_d  = ARMING;
          tmr_d = 8'd1;
        end
      end
      ARMING: if (!both) begin
        st_d  = IDLE;
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q + 8'd1;
        if (tmr_d == 8'(ALARM_CYCLES)) begin
          st_d  = ALARM;
          tmr_d = '0;
        end
      end
      ALARM: if (ack && !both) st_d = IDLE;
      default: begin
        st_d  = IDLE;
        tmr_d = '0;
      end
    endcase
    arming_d = st_d == ARMING;
`ifdef HUMIDITY_ALARM_BLINK_EN
    alarm_d = (st_d == ALARM) && (st_q != ALARM || !alarm_q);
`else
    alarm_d = st_d == ALARM;
`endif
  end
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      dry_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      ev_q     <= '0;
      st_q     <= IDLE;
      tmr_q    <= '0;
      alarm_q  <= 1'b0;
      arming_q <= 1'b0;
    end else begin
      s1_q     <= sensor_raw;
      s2_q     <= s1_q;
      dry_q    <= dry_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      ev_q     <= ev_d;
      st_q     <= st_d;
      tmr_q    <= tmr_d;
      alarm_q  <= alarm_d;
      arming_q <= arming_d;
    end
  end
  assign dry        = dry_q;
  assign alarm      = alarm_q;
  assign arming     = arming_q;
  assign dry_events = ev_q;
endmodule

// File: tb/tb_humidity_sensor_filter.sv
// tb_humidity_sensor_filter: scoreboard bench; a behavioural model pushes expected outputs per driven cycle.
module tb_humidity_sensor_filter;
  localparam int DB = 3;
  localparam int AN = 4;
  typedef struct {
    logic [1:0] dry;
    logic       al;
    logic       ar;
    logic [7:0] ev;
  } exp_t;
  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sensor_raw = 2'b00;
  logic       ack = 1'b0;
  logic [1:0] dry;
  logic       alarm, arming;
  logic [7:0] dry_events;
  exp_t       sb [$];
  int         n_cmp = 0, n_bad = 0;
  logic [1:0] m_s1, m_s2, m_dry;
  int         m_run [2];
  int         m_ev, m_both_run;
  bit         m_in_alarm, m_al;

  humidity_sensor_filter dut (
    .clk_2(clk_2), .reset(reset), .sensor_raw(sensor_raw), .ack(ack),
    .dry(dry), .alarm(alarm), .arming(arming), .dry_events(dry_events)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_dry = 0; m_run[0] = 0; m_run[1] = 0;
    m_ev = 0; m_both_run = 0; m_in_alarm = 0; m_al = 0;
    sb.delete();
  endtask

  // Alarm modelled as a run length of consecutive both-dry cycles rather than a state machine.
  task automatic model_step(input logic [1:0] raw, input logic a);
    logic [1:0] nd;
    bit both, entered;
    exp_t e;
    nd = m_dry;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] == m_dry[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] >= DB) begin
          nd[i] = ~nd[i];
          m_run[i] = 0;
        end
      end
    end
    for (int i = 0; i < 2; i++) if (nd[i] && !m_dry[i]) m_ev++;
    if (m_ev > 255) m_ev = 255;
    both = m_dry == 2'b11;
    entered = 0;
    if (m_in_alarm) begin
      if (a && !both) m_in_alarm = 0;
    end else begin
      m_both_run = both ? m_both_run + 1 : 0;
      if (m_both_run >= AN) begin
        m_in_alarm = 1;
        entered = 1;
        m_both_run = 0;
      end
    end
`ifdef HUMIDITY_ALARM_BLINK_EN
    m_al = m_in_alarm ? (entered ? 1'b1 : ~m_al) : 1'b0;
`else
    m_al = m_in_alarm;
`endif
    m_s2 = m_s1;
    m_s1 = raw;
    m_dry = nd;
    e.dry = m_dry;
    e.al = m_al;
    e.ar = !m_in_alarm && m_both_run > 0;
    e.ev = 8'(m_ev);
    sb.push_back(e);
  endtask

  task automatic tick(input logic [1:0] raw, input logic a);
    exp_t e;
    sensor_raw = raw;
    ack = a;
    model_step(raw, a);
    @(posedge clk_2);
    #1;
    e = sb.pop_front();
    check("dry", dry, e.dry);
    check("alarm", alarm, e.al);
    check("arming", arming, e.ar);
    check("events", dry_events, e.ev);
  endtask

  task automatic ticks(input int n, input logic [1:0] raw, input logic a);
    for (int k = 0; k < n; k++) tick(raw, a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dry"}, dry, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_arming"}, arming, 0);
    check({tag, "_events"}, dry_events, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sensor_raw = 2'b00;
    ack = 1'b0;
    model_clear();
    #12;
    check_zero("rst");
    @(negedge clk_2);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    // Stable channel 0 input shows up on the fifth edge.
    for (int k = 1; k <= 5; k++) begin
      tick(2'b01, 1'b0);
      check($sformatf("lat_e%0d", k), dry, k == 5 ? 2'b01 : 2'b00);
    end
    check("ev_first", dry_events, 1);
    // Two-cycle glitch on channel 1 is rejected.
    ticks(2, 2'b11, 1'b0);
    ticks(6, 2'b01, 1'b0);
    check("glitch_dry", dry, 2'b01);
    check("glitch_ev", dry_events, 1);
    // Both rise together, then the alarm latches.
    ticks(6, 2'b00, 1'b0);
    ticks(12, 2'b11, 1'b0);
    check("both_ev", dry_events, 3);
    check("alarm_on", alarm === 1'b1 || 1'b1 == 1'b0 ? 1 : 0, 1);
    ticks(2, 2'b11, 1'b1);
    ticks(8, 2'b00, 1'b0);
    check("alarm_latched_dry", dry, 2'b00);
    tick(2'b00, 1'b1);
    check("alarm_cleared", alarm, 0);
    tick(2'b00, 1'b0);
    // Brief both-dry window: arming starts then aborts.
    ticks(3, 2'b11, 1'b0);
    ticks(10, 2'b10, 1'b0);
    check("abort_ev", dry_events, 5);
    // Reset asserted while arming clears everything asynchronously.
    ticks(7, 2'b11, 1'b0);
    check("arming_pre", arming, 1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_zero("async_rst");
    @(negedge clk_2);
    reset = 1'b1;
    // 130 rises on both channels saturate the counter.
    for (int k = 0; k < 130; k++) begin
      ticks(4, 2'b11, 1'b0);
      ticks(4, 2'b00, 1'b0);
    end
    ticks(6, 2'b00, 1'b0);
    check("sat_ev", dry_events, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/humidity_sensor_filter.md
Name: humidity_sensor_filter

Overview:
- Conditioning stage directly upstream of the two-sensor humidity status decoder that drives SEG.
- Synchronizes and debounces the two raw low-humidity sensor lines, then hands clean dry[1:0] flags to the decoder in place of raw SWI bits.
- Adds a persistence alarm (both sensors dry for a sustained time, cleared by operator acknowledge) and a saturating dry-event counter for the LCD debug outputs.

Parameters:
- DB_CYCLES, 3, consecutive synchronized cycles an input must disagree with its flag before the flag toggles (legal range 1..15).
- ALARM_CYCLES, 4, consecutive cycles with dry==2'b11 before alarm asserts (legal range 1..255).
- CNT_W, 8, width of the dry-event counter.

Ports:
- clk_2  input  1  system clock (divided reference clock).
- reset  input  1  asynchronous, active-low reset.
- sensor_raw  input  2  raw sensor lines; 1 = low humidity at sensor i; asynchronous to clk_2.
- ack  input  1  operator acknowledge, level-sampled on clk_2.
- dry  output  2  debounced low-humidity flags, feed the status decoder.
- alarm  output  1  persistence alarm.
- arming  output  1  high while the alarm timer is running.
- dry_events  output  CNT_W  saturating count of dry-flag rising edges.

Behaviour:
- Reset (reset==0, asynchronous): sync flops = 0, debounce counters = 0, dry = 2'b00, FSM = IDLE, alarm = 0, arming = 0, timer = 0, dry_events = 0. Reset asserted mid-debounce or mid-alarm aborts immediately. Operation resumes on the first clk_2 edge after release.
- Synchronizer: per channel, two flops, s1 <= sensor_raw[i] and s2 <= s1.
- Debounce, per channel:
  - If s2 == dry[i], the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DB_CYCLES, dry[i] toggles and the counter clears instead.
  - Latency: a raw change held stable appears on dry[i] at the (DB_CYCLES+2)th rising edge after it. With the default, that is the 5th edge.
  - A glitch shorter than DB_CYCLES synchronized cycles produces no dry change.
- Channels are fully independent. Both may toggle on the same edge.
- dry_events:
  - +1 per dry[i] 0->1 transition. Both channels rising on the same edge gives +2.
  - Saturates at 2^CNT_W-1, with no wrap. The +2 at max-1 also saturates at max.
  - Falling transitions are not counted.
- Alarm FSM, 3 states; timer is CNT_W-independent 8-bit:
  - IDLE: alarm=0, arming=0. dry==2'b11 -> ARMING with timer=1. If ALARM_CYCLES==1, go straight to ALARM instead.
  - ARMING: arming=1. dry!=2'b11 -> IDLE with timer=0. Otherwise the timer increments. When it reaches ALARM_CYCLES -> ALARM.
  - ALARM: alarm=1, arming=0. ack==1 with dry!=2'b11 -> IDLE. ack==1 with dry==2'b11 is ignored (stays ALARM). dry dropping without ack stays ALARM (alarm is latched).
  - ack in IDLE or ARMING has no effect.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: HUMIDITY_ALARM_BLINK_EN.
- Defined: in ALARM, alarm toggles on every clk_2 edge, starting at 1 on entry. It returns to 0 on exit. Intended for direct LED drive.
- Undefined: alarm is steady 1 throughout ALARM.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then sensor_raw=2'b01 held -> dry=2'b00 for edges 1-4, dry=2'b01 on edge 5, dry_events=1.
- sensor_raw[1] pulse of 2 cycles, then back to 0 -> dry[1] stays 0 and dry_events is unchanged.
- Both sensors rise together and are held -> dry=2'b11 on edge 5, dry_events=+2, arming=1 for 3 cycles, alarm=1 at the 4th edge after dry==2'b11.
- In ALARM, ack=1 with dry==2'b11 -> alarm stays 1. Release sensors, wait for dry=2'b00, ack=1 -> IDLE with alarm=0 on the next edge.
- dry==2'b11 for 2 cycles, then sensor 0 drops -> arming returns to 0 and alarm never asserts. Assert reset during ARMING -> all outputs 0 immediately, asynchronously.
- Toggle both sensors 130 times -> dry_events saturates at 255 and does not wrap. With HUMIDITY_ALARM_BLINK_EN defined, alarm alternates 1,0,1,... every edge while in ALARM.
